// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared types and encodings for the RV32I-subset decode stage
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_ADD     = 4'd2,
        OP_SUB     = 4'd3,
        OP_ADDI    = 4'd4,
        OP_SLL     = 4'd5,
        OP_BEQ     = 4'd6,
        OP_SW      = 4'd7,
        OP_LW      = 4'd8,
        OP_ILLEGAL = 4'd9
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        we;
        logic [31:0] pc;
    } dec_s;

    // Bundle presented while nothing valid has been decoded since reset
    function automatic dec_s dec_reset();
        dec_s d;
        d    = '0;
        d.op = OP_ILLEGAL;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_comb
// Description : Purely combinational split of one instruction word into
//               op class, register indices and sign-extended immediate
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode_comb
    import id_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output dec_s        dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  f_rd;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;

    assign opcode = instr[6:0];
    assign f_rd   = instr[11:7];
    assign funct3 = instr[14:12];
    assign f_rs1  = instr[19:15];
    assign f_rs2  = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    // Classify the word and keep only the fields its format actually uses
    always_comb begin
        logic writes;
        writes = 1'b0;
        dec    = '0;
        dec.op = OP_ILLEGAL;
        dec.pc = pc;
        case (opcode)
            OPC_LUI: begin
                dec.op = OP_LUI;   dec.rd = f_rd; dec.imm = imm_u; writes = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op = OP_AUIPC; dec.rd = f_rd; dec.imm = imm_u; writes = 1'b1;
            end
            OPC_OP: begin
                if ((funct3 == F3_ADD_SUB) && (funct7 == F7_BASE)) begin
                    dec.op = OP_ADD;
                end else if ((funct3 == F3_ADD_SUB) && (funct7 == F7_ALT)) begin
                    dec.op = OP_SUB;
                end else if ((funct3 == F3_SLL) && (funct7 == F7_BASE)) begin
                    dec.op = OP_SLL;
                end
                if (dec.op != OP_ILLEGAL) begin
                    dec.rd = f_rd; dec.rs1 = f_rs1; dec.rs2 = f_rs2; writes = 1'b1;
                end
            end
            OPC_OP_IMM: if (funct3 == F3_ADDI) begin
                dec.op = OP_ADDI; dec.rd = f_rd; dec.rs1 = f_rs1; dec.imm = imm_i; writes = 1'b1;
            end
            OPC_LOAD: if (funct3 == F3_WORD) begin
                dec.op = OP_LW;   dec.rd = f_rd; dec.rs1 = f_rs1; dec.imm = imm_i; writes = 1'b1;
            end
            OPC_BRANCH: if (funct3 == F3_BEQ) begin
                dec.op = OP_BEQ;  dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.imm = imm_b;
            end
            OPC_STORE: if (funct3 == F3_WORD) begin
                dec.op = OP_SW;   dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.imm = imm_s;
            end
            default: ;
        endcase
        // x0 writes are suppressed here so execute never has to check rd
        dec.we = writes && (dec.rd != 5'd0);
    end

endmodule
`default_nettype wire

// File: rtl/id_decoder.sv
`default_nettype none
// ============================================================================
// Module      : id_decoder
// Description : Decode stage with a 2-entry skid buffer; upstream ready is a
//               state-register bit so it never depends on downstream ready
// Revision    : 1.0 - initial release
// ============================================================================
module id_decoder
    import id_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [3:0]  o_op,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [31:0] o_imm,
    output logic        o_we,
    output logic [31:0] o_pc,
    output logic        o_illegal
);

    // Encoding chosen so bit 0 is "main occupied" and bit 1 is "skid occupied"
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [1:0] state;
    logic [1:0] state_next;
    dec_s       dec_in;
    dec_s       main_q;
    dec_s       skid_q;
    logic       accept;
    logic       drain;

    id_decode_comb u_decode (
        .instr (i_instr),
        .pc    (i_pc),
        .dec   (dec_in)
    );

    assign accept = i_valid & o_ready;
    assign drain  = o_valid & i_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy transitions; a flush overrides any accept or drain
    always_comb begin
        state_next = state;
        if (i_flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_next = ST_ONE;
                ST_ONE: begin
                    if (accept && !drain)      state_next = ST_FULL;
                    else if (!accept && drain) state_next = ST_EMPTY;
                end
                ST_FULL:  if (drain) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs decoded directly from the state flops
    always_comb begin
        o_valid = state[0];
        o_ready = ~state[1];
    end

    // Main/skid data registers; skid only fills when main cannot drain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q <= dec_reset();
            skid_q <= dec_reset();
        end else if (!i_flush) begin
            case (state)
                ST_EMPTY: if (accept) main_q <= dec_in;
                ST_ONE: begin
                    if (accept && drain) main_q <= dec_in;
                    else if (accept)     skid_q <= dec_in;
                end
                ST_FULL:  if (drain) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign o_op      = main_q.op;
    assign o_rd      = main_q.rd;
    assign o_rs1     = main_q.rs1;
    assign o_rs2     = main_q.rs2;
    assign o_imm     = main_q.imm;
    assign o_we      = main_q.we;
    assign o_pc      = main_q.pc;
    assign o_illegal = (main_q.op == OP_ILLEGAL);

endmodule
`default_nettype wire

// File: tb/tb_id_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_decoder
// Description : Scoreboard bench for id_decoder with directed and random
//               traffic against an arithmetic reference of the decode rules
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_decoder;
    import id_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_op;
    logic [4:0]  o_rd;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [31:0] o_imm;
    logic        o_we;
    logic [31:0] o_pc;
    logic        o_illegal;

    int   checks = 0;
    int   errors = 0;
    dec_s q[$];
    int   held = 0;

    always #5 i_clk = ~i_clk;

    id_decoder dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_op(o_op), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_imm(o_imm), .o_we(o_we), .o_pc(o_pc), .o_illegal(o_illegal)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode: field extraction and immediates by plain arithmetic
    function automatic dec_s model(input logic [31:0] w, input logic [31:0] pc);
        dec_s d;
        int   opc, f3, f7, rd, rs1, rs2, hi, imm_i, imm_s, imm_b;
        logic writes;
        opc   = int'(w & 32'h7F);
        rd    = int'((w >> 7) & 32'h1F);
        f3    = int'((w >> 12) & 32'h7);
        rs1   = int'((w >> 15) & 32'h1F);
        rs2   = int'((w >> 20) & 32'h1F);
        f7    = int'(w >> 25);
        imm_i = $signed(w) >>> 20;
        hi    = $signed(w) >>> 25;
        imm_s = hi * 32 + int'((w >> 7) & 32'h1F);
        imm_b = int'((w >> 8) & 32'hF) * 2 + int'((w >> 25) & 32'h3F) * 32
              + int'((w >> 7) & 32'h1) * 2048;
        if (w[31]) imm_b = imm_b - 4096;
        d = '0; d.op = OP_ILLEGAL; d.pc = pc; writes = 1'b0;
        if (opc == 'h37 || opc == 'h17) begin
            d.op = (opc == 'h37) ? OP_LUI : OP_AUIPC;
            d.rd = rd[4:0]; d.imm = w & 32'hFFFFF000; writes = 1'b1;
        end else if (opc == 'h33 && f3 == 0 && (f7 == 0 || f7 == 32) || opc == 'h33 && f3 == 1 && f7 == 0) begin
            d.op = (f3 == 1) ? OP_SLL : ((f7 == 32) ? OP_SUB : OP_ADD);
            d.rd = rd[4:0]; d.rs1 = rs1[4:0]; d.rs2 = rs2[4:0]; writes = 1'b1;
        end else if ((opc == 'h13 && f3 == 0) || (opc == 'h03 && f3 == 2)) begin
            d.op = (opc == 'h13) ? OP_ADDI : OP_LW;
            d.rd = rd[4:0]; d.rs1 = rs1[4:0]; d.imm = imm_i; writes = 1'b1;
        end else if ((opc == 'h63 && f3 == 0) || (opc == 'h23 && f3 == 2)) begin
            d.op  = (opc == 'h63) ? OP_BEQ : OP_SW;
            d.rs1 = rs1[4:0]; d.rs2 = rs2[4:0];
            d.imm = (opc == 'h63) ? imm_b : imm_s;
        end
        d.we = writes && (d.rd != 5'd0);
        return d;
    endfunction

    // Monitor: occupancy model, in-order scoreboard pop, hold-while-stalled
    always @(negedge i_clk) begin
        dec_s cur, e, prev;
        logic prev_stall;
        cur = '0;
        cur.op = op_e'(o_op); cur.rd = o_rd; cur.rs1 = o_rs1; cur.rs2 = o_rs2;
        cur.imm = o_imm; cur.we = o_we; cur.pc = o_pc;
        if (!i_rst_n) begin
            q.delete();
            held       = 0;
            prev_stall = 1'b0;
        end else begin
            chk("valid_vs_model", o_valid, held > 0);
            chk("ready_vs_model", o_ready, held < 2);
            if (prev_stall) chk("stall_hold", cur, prev);
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("drain_without_expected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("bundle", cur, e);
                    chk("illegal_flag", o_illegal, e.op == OP_ILLEGAL);
                end
            end
            if (i_flush) begin
                q.delete();
                held = 0;
            end else begin
                held = held + int'(i_valid && o_ready) - int'(o_valid && i_ready);
            end
            prev_stall = o_valid && !i_ready && !i_flush;
            prev       = cur;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        i_valid = 1'b1; i_instr = w; i_pc = pc;
        for (int n = 0; n < 50; n++) begin
            if (o_ready) begin
                q.push_back(model(w, pc));
                tick();
                i_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("send_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic we);
        chk({tag, "_valid"}, o_valid, 1);
        chk({tag, "_op"},    o_op,    op);
        chk({tag, "_rd"},    o_rd,    rd);
        chk({tag, "_rs1"},   o_rs1,   rs1);
        chk({tag, "_rs2"},   o_rs2,   rs2);
        chk({tag, "_imm"},   o_imm,   imm);
        chk({tag, "_we"},    o_we,    we);
    endtask

    task automatic expect_reset_outputs(input string tag);
        chk({tag, "_valid"},   o_valid,   0);
        chk({tag, "_ready"},   o_ready,   1);
        chk({tag, "_op"},      o_op,      OP_ILLEGAL);
        chk({tag, "_illegal"}, o_illegal, 1);
        chk({tag, "_fields"},  {o_rd, o_rs1, o_rs2, o_imm, o_pc, o_we}, 0);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r = {r[31:7], 7'h37};
            1: r = {r[31:7], 7'h17};
            2: r = (r & 32'h01FF8F80) | 32'h00000033;
            3: r = (r & 32'h01FF8F80) | 32'h40000033;
            4: r = (r & 32'h01FF8F80) | 32'h00001033;
            5: r = (r & ~32'h0000707F) | 32'h00000013;
            6: r = (r & ~32'h0000707F) | 32'h00000063;
            7: r = (r & ~32'h0000707F) | 32'h00002023;
            8: r = (r & ~32'h0000707F) | 32'h00002003;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0;
        i_flush = 1'b0; i_ready = 1'b1;
        #12;
        expect_reset_outputs("reset");
        tick();
        i_rst_n = 1'b1;
        tick();

        // Single instructions with fixed expectations
        send(32'h00108093, 32'd0);
        expect_out("addi", OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd1, 1'b1);
        send(32'hFE0086E3, 32'd36);
        expect_out("beq", OP_BEQ, 5'd0, 5'd1, 5'd0, 32'hFFFFFFEC, 1'b0);
        chk("beq_pc", o_pc, 36);
        send(32'h00ABF437, 32'd40);
        expect_out("lui", OP_LUI, 5'd8, 5'd0, 5'd0, 32'h00ABF000, 1'b1);
        send(32'h00902223, 32'd44);
        expect_out("sw", OP_SW, 5'd0, 5'd0, 5'd9, 32'd4, 1'b0);
        tick();

        // Backpressure into FULL, then ordered release
        i_ready = 1'b0;
        send(32'h408484B3, 32'd100);
        send(32'h00000033, 32'd104);
        chk("full_ready", o_ready, 0);
        chk("full_head_op", o_op, OP_SUB);
        tick();
        chk("full_hold_op", o_op, OP_SUB);
        i_ready = 1'b1;
        tick();
        chk("release_second_op", o_op, OP_ADD);
        chk("release_x0_we", o_we, 0);
        chk("release_ready", o_ready, 1);
        tick();
        chk("release_empty", o_valid, 0);

        // Illegal encodings
        send(32'h00000000, 32'd200);
        expect_out("ill_zero", OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        chk("ill_zero_flag", o_illegal, 1);
        send(32'h021080B3, 32'd204);
        expect_out("ill_f7", OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        tick();

        // Flush while FULL with a concurrent offer
        i_ready = 1'b0;
        send(32'h00108093, 32'd300);
        send(32'h00208113, 32'd304);
        chk("pre_flush_ready", o_ready, 0);
        i_valid = 1'b1; i_instr = 32'h00308193; i_pc = 32'd308; i_flush = 1'b1;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_valid", o_valid, 0);
        chk("flush_ready", o_ready, 1);
        i_ready = 1'b1;
        send(32'h00ABF437, 32'd312);
        expect_out("post_flush", OP_LUI, 5'd8, 5'd0, 5'd0, 32'h00ABF000, 1'b1);
        chk("post_flush_pc", o_pc, 312);
        tick();

        // Asynchronous reset while one instruction is held
        i_ready = 1'b0;
        send(32'h00108093, 32'd400);
        chk("pre_reset_valid", o_valid, 1);
        #2 i_rst_n = 1'b0;
        #1 expect_reset_outputs("async_reset");
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        send(32'h00ABF437, 32'h200);
        expect_out("after_reset", OP_LUI, 5'd8, 5'd0, 5'd0, 32'h00ABF000, 1'b1);
        chk("after_reset_pc", o_pc, 32'h200);

        // Random traffic; the monitor checks every drain against the model
        for (int c = 0; c < 600; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 31) == 0);
            i_instr = gen_instr();
            i_pc    = $urandom & 32'hFFFFFFFC;
            if (i_valid && o_ready && !i_flush) q.push_back(model(i_instr, i_pc));
            tick();
        end

        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        repeat (4) tick();
        chk("scoreboard_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_decoder.md
# id_decoder

Decode stage for the RV32I subset the core currently executes (LUI, AUIPC, ADD, SUB, ADDI, SLL, BEQ, SW, LW). It sits between instruction fetch and execute. It accepts raw 32-bit instruction words with their PC over a valid/ready handshake and splits each one into opcode class, register indices and a sign-extended immediate. Results are registered behind a 2-entry skid buffer so the upstream ready is a flop output.

## Interface
- No parameters; XLEN fixed at 32.
- i_clk  in  1  core clock, all state updates on posedge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  fetch presents i_instr/i_pc
- o_ready  out  1  stage can accept; registered
- i_instr  in  32  raw instruction word
- i_pc  in  32  address of i_instr
- i_flush  in  1  discard all held and incoming instructions (branch redirect)
- o_valid  out  1  decoded instruction available
- i_ready  in  1  execute accepts decoded instruction
- o_op  out  4  op_e class (see Structure)
- o_rd, o_rs1, o_rs2  out  5 each  register indices, 0 when unused by the op
- o_imm  out  32  sign-extended immediate, 0 for R-type and illegal
- o_we  out  1  register write enable (op writes rd and rd != 0)
- o_pc  out  32  PC of decoded instruction
- o_illegal  out  1  o_op == OP_ILLEGAL

## Operation
- Decode is combinational on i_instr. Each transfer (i_valid & o_ready) writes the decoded bundle into the main register, or into the skid register if main is occupied and not draining.
- Op rules, all checked on opcode[6:0], funct3 and funct7:
  - 0110111 → LUI
  - 0010111 → AUIPC
  - 0110011 with f3=000/f7=0000000 → ADD
  - 0110011 with f3=000/f7=0100000 → SUB
  - 0110011 with f3=001/f7=0 → SLL
  - 0010011 with f3=000 → ADDI
  - 1100011 with f3=000 → BEQ
  - 0100011 with f3=010 → SW
  - 0000011 with f3=010 → LW
  - anything else → OP_ILLEGAL
- Immediates:
  - I = sext(instr[31:20])
  - S = sext({instr[31:25], instr[11:7]})
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U = {instr[31:12], 12'b0}
- Field zeroing: U-type → rs1 = rs2 = 0; I-type → rs2 = 0; BEQ/SW → rd = 0. Illegal → all indices 0, o_we = 0.
- States:
  - EMPTY: o_valid = 0, o_ready = 1
  - ONE: o_valid = 1, o_ready = 1
  - FULL: o_valid = 1, o_ready = 0
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain (o_valid & i_ready) without accept.
  - ONE stays ONE on accept and drain together.
  - ONE→FULL on accept without drain.
  - FULL→ONE on drain: skid moves to main. No accept is possible in FULL.
- Output order equals acceptance order. No instruction is dropped or duplicated except by flush.

## Timing
- Latency: accept in cycle N → o_valid with that bundle in N+1.
- Throughput: 1 instruction per cycle while i_ready stays high.
- o_ready deasserts the cycle after entering FULL. It reasserts the cycle after the first drain from FULL.
- Outputs hold stable while o_valid & ~i_ready.
- i_flush: the next state is EMPTY regardless of any drain or accept in the same cycle. An instruction presented in the flush cycle is discarded. Flush has priority over every other event.
- Reset (asynchronous, mid-operation included):
  - state EMPTY, o_valid = 0, o_ready = 1
  - o_op = OP_ILLEGAL, o_illegal = 1
  - o_rd/o_rs1/o_rs2/o_imm/o_pc/o_we = 0
  - held instructions are lost

## Structure
- Shared package id_pkg holds:
  - op_e (4-bit enum: OP_LUI, OP_AUIPC, OP_ADD, OP_SUB, OP_ADDI, OP_SLL, OP_BEQ, OP_SW, OP_LW, OP_ILLEGAL)
  - opcode/funct3/funct7 localparams
  - packed struct dec_s {op, rd, rs1, rs2, imm, we, pc}
- One combinational sub-module, id_decode_comb (instr, pc → dec_s), reusable by the verification model. The skid buffer and state machine live in id_decoder.

## Test plan
- Single ADDI 0x00108093, pc=0 → next cycle o_valid = 1, OP_ADDI, rd = rs1 = 1, rs2 = 0, imm = 1, we = 1.
- BEQ 0xFE0086E3 at pc=36 → OP_BEQ, rs1 = 1, rs2 = 0, rd = 0, imm = 0xFFFFFFEC, we = 0. LUI 0x00ABF437 → rd = 8, imm = 0x00ABF000. SW 0x00902223 → rs2 = 9, imm = 4.
- Backpressure: i_ready = 0 while streaming SUB 0x408484B3 then ADD x0 0x00000033 → FULL, o_ready = 0 one cycle later. On release, both drain in order with no loss, and o_we = 0 for the x0 write.
- Illegal 0x00000000 and ADD with f7=0000001 → OP_ILLEGAL, o_illegal = 1, all indices and imm 0.
- Flush while FULL with a concurrent i_valid → next cycle o_valid = 0, o_ready = 1, and the stream resumes cleanly with the next instruction.
- Assert reset while ONE → o_valid drops immediately (asynchronous), all outputs take their reset values, and the first post-reset accept appears one cycle later.
